// File: rtl/sqrt_batch_sequencer_if.sv
// Bus bundle between the batch sequencer and its neighbours: host load port,
// shared RAM port, SquareRoot handshake and result stream.
interface sqrt_batch_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int ROOT_W = 4
);
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_rej;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              sq_st;
  logic [DATA_W-1:0] sq_n;
  logic              sq_done;
  logic [ROOT_W-1:0] sq_root;

  logic              res_valid;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_n;
  logic [ROOT_W-1:0] res_root;

  modport master (
    input  ld_we, ld_addr, ld_data, mem_rdata, sq_done, sq_root,
    output ld_rej, mem_addr, mem_we, mem_wdata, sq_st, sq_n,
           res_valid, res_addr, res_n, res_root
  );

  modport slave (
    output ld_we, ld_addr, ld_data, mem_rdata, sq_done, sq_root,
    input  ld_rej, mem_addr, mem_we, mem_wdata, sq_st, sq_n,
           res_valid, res_addr, res_n, res_root
  );
endinterface

// File: rtl/sqrt_batch_sequencer.sv
// Batch sequencer: walks a RAM address range and runs SquareRoot once per word.
// Optional root checker with chk_err/err_cnt when SQRT_CHECK_EN is defined.
//
// state   | meaning
// IDLE    | host owns the RAM port, waiting for Start
// RD      | present cur to the RAM
// RDW     | RAM read latency, capture word into n_reg
// LAUNCH  | one-cycle sq_st pulse
// WAIT_LO | wait for the previous word's Done to drop
// WAIT_HI | wait for Done, emit result, advance or finish
// FIN     | one-cycle BatchDone pulse
module sqrt_batch_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int ROOT_W = 4
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              Start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              Busy,
  output logic              BatchDone,
`ifdef SQRT_CHECK_EN
  output logic              chk_err,
  output logic [ADDR_W:0]   err_cnt,
`endif
  sqrt_batch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD, RDW, LAUNCH, WAIT_LO, WAIT_HI, FIN
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur, last_r;
  logic [DATA_W-1:0] n_reg;
  logic              start_ok;

  assign start_ok = (state == IDLE) && Start;

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state  <= IDLE;
      cur    <= '0;
      last_r <= '0;
      n_reg  <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        cur    <= first_addr;
        last_r <= last_addr;
      end else if (state == WAIT_HI && bus.sq_done && cur != last_r) begin
        cur <= cur + 1'b1;
      end
      if (state == RDW) n_reg <= bus.mem_rdata;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.mem_addr  = cur;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.ld_rej    = 1'b0;
    bus.sq_st     = 1'b0;
    bus.sq_n      = '0;
    bus.res_valid = 1'b0;
    bus.res_addr  = '0;
    bus.res_n     = '0;
    bus.res_root  = '0;
    Busy          = 1'b1;
    BatchDone     = 1'b0;
    case (state)
      IDLE: begin
        Busy          = 1'b0;
        bus.mem_addr  = bus.ld_addr;
        bus.mem_we    = bus.ld_we;
        bus.mem_wdata = bus.ld_data;
        if (Start) state_nx = RD;
      end
      RD:     state_nx = RDW;
      RDW:    state_nx = LAUNCH;
      LAUNCH: begin
        bus.sq_st = 1'b1;
        bus.sq_n  = n_reg;
        state_nx  = WAIT_LO;
      end
      WAIT_LO: begin
        bus.sq_n = n_reg;
        if (!bus.sq_done) state_nx = WAIT_HI;
      end
      WAIT_HI: begin
        bus.sq_n = n_reg;
        if (bus.sq_done) begin
          bus.res_valid = 1'b1;
          bus.res_addr  = cur;
          bus.res_n     = n_reg;
          bus.res_root  = bus.sq_root;
          state_nx      = (cur == last_r) ? FIN : RD;
        end
      end
      FIN: begin
        BatchDone = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Host writes are dropped outside IDLE; flag each one.
    if (state != IDLE) bus.ld_rej = bus.ld_we;
  end

`ifdef SQRT_CHECK_EN
  logic [2*ROOT_W:0] root_ext, root_inc, lo_sq, hi_sq, n_ext;
  logic              mismatch;

  always_comb begin
    root_ext = {{(ROOT_W+1){1'b0}}, bus.sq_root};
    root_inc = root_ext + 1'b1;
    lo_sq    = root_ext * root_ext;
    hi_sq    = root_inc * root_inc;
    n_ext    = {1'b0, n_reg};
    mismatch = (lo_sq > n_ext) || (n_ext >= hi_sq);
    chk_err  = bus.res_valid && mismatch;
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN)                       err_cnt <= '0;
    else if (start_ok)                 err_cnt <= '0;
    else if (chk_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_sqrt_batch_sequencer.sv
// Directed bench for sqrt_batch_sequencer with RAM and SquareRoot models and a result scoreboard.
module tb_sqrt_batch_sequencer;

  logic       CLK = 1'b0;
  logic       ResetN = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] first_addr = '0;
  logic [3:0] last_addr = '0;
  logic       Busy, BatchDone;
`ifdef SQRT_CHECK_EN
  logic       chk_err;
  logic [4:0] err_cnt;
`endif

  sqrt_batch_sequencer_if #(.ADDR_W(4), .DATA_W(8), .ROOT_W(4)) bus ();

  sqrt_batch_sequencer #(.ADDR_W(4), .DATA_W(8), .ROOT_W(4)) dut (
    .CLK        (CLK),
    .ResetN     (ResetN),
    .Start      (Start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .Busy       (Busy),
    .BatchDone  (BatchDone),
`ifdef SQRT_CHECK_EN
    .chk_err    (chk_err),
    .err_cnt    (err_cnt),
`endif
    .bus        (bus.master)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  function automatic int isqrt(input int n);
    int r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // RAM model: registered read, one-cycle latency
  logic [7:0] ram [16];
  always @(posedge CLK) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // SquareRoot model: Done stays high until one cycle after the next start
  int         sq_lat = 3;
  bit         force_bad = 1'b0;
  int         sq_cnt;
  bit         stale;
  logic [7:0] n_hold;
  always @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      bus.sq_done <= 1'b0;
      bus.sq_root <= '0;
      sq_cnt      <= 0;
      stale       <= 1'b0;
      n_hold      <= '0;
    end else if (bus.sq_st) begin
      stale  <= 1'b1;
      sq_cnt <= sq_lat;
      n_hold <= bus.sq_n;
    end else begin
      if (stale) begin
        bus.sq_done <= 1'b0;
        stale       <= 1'b0;
      end
      if (sq_cnt > 1) sq_cnt <= sq_cnt - 1;
      else if (sq_cnt == 1) begin
        sq_cnt      <= 0;
        bus.sq_done <= 1'b1;
        bus.sq_root <= (force_bad && n_hold == 8'd24) ? 4'd5 : 4'(isqrt(int'(n_hold)));
      end
    end
  end

  typedef struct {int a; int n; int r; bit e;} exp_t;
  exp_t       q[$];
  logic [7:0] ram_exp [16];

  task automatic ld_write(input int a, input int d);
    @(negedge CLK);
    bus.ld_we   = 1'b1;
    bus.ld_addr = 4'(a);
    bus.ld_data = 8'(d);
    ram_exp[a]  = 8'(d);
    @(negedge CLK);
    bus.ld_we = 1'b0;
  endtask

  task automatic run_batch(input int f, input int l, input bit inject);
    int   len, cyc, last_res;
    bit   fin;
    exp_t e;
    len = ((l - f) & 15) + 1;
    for (int i = 0; i < len; i++) begin
      e.a = (f + i) & 15;
      e.n = int'(ram_exp[e.a]);
      e.e = force_bad && e.n == 24;
      e.r = e.e ? 5 : isqrt(e.n);
      q.push_back(e);
    end
    @(negedge CLK);
    Start      = 1'b1;
    first_addr = 4'(f);
    last_addr  = 4'(l);
    @(negedge CLK);
    Start = 1'b0;
    chk("busy_after_start", 32'(Busy), 32'd1);
    fin = 1'b0;
    last_res = -10;
    for (cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge CLK);
      if (bus.res_valid) begin
        if (q.size() == 0) chk("extra_result", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("res_addr", 32'(bus.res_addr), 32'(e.a));
          chk("res_n", 32'(bus.res_n), 32'(e.n));
          chk("res_root", 32'(bus.res_root), 32'(e.r));
`ifdef SQRT_CHECK_EN
          chk("chk_err", 32'(chk_err), 32'(e.e));
`endif
        end
        last_res = cyc;
      end
      if (BatchDone) begin
        fin = 1'b1;
        chk("batchdone_timing", 32'(cyc), 32'(last_res + 1));
        chk("results_left", 32'(q.size()), 32'd0);
      end
      if (inject && cyc == 6) begin
        bus.ld_we   = 1'b1;
        bus.ld_addr = 4'd3;
        bus.ld_data = 8'd99;
        Start       = 1'b1;
        first_addr  = 4'd9;
        last_addr   = 4'd9;
        #1;
        chk("ld_rej_busy", 32'(bus.ld_rej), 32'd1);
        chk("mem_we_busy", 32'(bus.mem_we), 32'd0);
      end
      if (inject && cyc == 7) begin
        bus.ld_we = 1'b0;
        Start     = 1'b0;
      end
    end
    if (!fin) chk("batch_timeout", 32'd0, 32'd1);
    q.delete();
    @(negedge CLK);
    chk("busy_after_done", 32'(Busy), 32'd0);
  endtask

  int vals[16] = '{0, 1, 2, 3, 4, 8, 9, 15, 16, 24, 25, 63, 64, 100, 225, 255};
  int roots[16] = '{0, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 7, 8, 10, 15, 15};

  initial begin
    int seen_rv, seen_bd, w;
    bus.ld_we   = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_batchdone", 32'(BatchDone), 32'd0);
    chk("rst_sq_st", 32'(bus.sq_st), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_ld_rej", 32'(bus.ld_rej), 32'd0);
    chk("rst_sq_n", 32'(bus.sq_n), 32'd0);
    ResetN = 1'b1;

    for (int i = 0; i < 16; i++) ld_write(i, vals[i]);
    for (int i = 0; i < 16; i++) chk("ram_load", 32'(ram[i]), 32'(vals[i]));
    for (int i = 0; i < 16; i++) chk("root_table", 32'(isqrt(vals[i])), 32'(roots[i]));

    // Reset while parked in WAIT_HI
    sq_lat = 20;
    @(negedge CLK);
    Start = 1'b1; first_addr = 4'd0; last_addr = 4'd15;
    @(negedge CLK);
    Start = 1'b0;
    w = 0;
    while (!bus.sq_st && w < 50) begin @(negedge CLK); w++; end
    if (w >= 50) chk("wait_sq_st_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge CLK);
    ResetN = 1'b0;
    #1;
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_sq_st", 32'(bus.sq_st), 32'd0);
    chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    @(negedge CLK);
    ResetN = 1'b1;
    seen_rv = 0; seen_bd = 0;
    repeat (40) begin
      @(negedge CLK);
      seen_rv += int'(bus.res_valid);
      seen_bd += int'(BatchDone);
    end
    chk("postrst_batchdone", 32'(seen_bd), 32'd0);
    chk("postrst_res_valid", 32'(seen_rv), 32'd0);

    sq_lat = 3;
    run_batch(0, 15, 1'b0);
    sq_lat = 2;
    run_batch(14, 1, 1'b0);
    sq_lat = 5;
    run_batch(7, 7, 1'b0);

    sq_lat = 6;
    run_batch(0, 7, 1'b1);
    chk("ram3_untouched", 32'(ram[3]), 32'd3);
    run_batch(3, 3, 1'b0);

`ifdef SQRT_CHECK_EN
    sq_lat = 3;
    force_bad = 1'b1;
    run_batch(0, 15, 1'b0);
    chk("err_cnt_bad", 32'(err_cnt), 32'd1);
    force_bad = 1'b0;
    run_batch(0, 15, 1'b0);
    chk("err_cnt_clean", 32'(err_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
